// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences PC/IR/memory/register-file
// enables and ALU source/op selects from the opcode, with a bounded mem_ready wait.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic [1:0] pc_source_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       instr_done_o,
  output logic       mem_err_o,
  output logic [3:0] state_o
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ADDIEX = 4'd9;
  localparam logic [3:0] S_ADDIWB = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

  logic [3:0] state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       waiting;
  logic       timeout;

  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                   && !mem_ready_i;
  assign timeout = waiting && (wait_q == TIMEOUT_CNT);

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode_i)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready_i ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
  end

  // A FETCH timeout stays in FETCH, so the counter must also clear on the abort itself.
  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || timeout) begin
      wait_d = 4'd0;
    end else if (waiting && (wait_q != 4'hF)) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    pc_source_o     = 2'b00;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 2'b00;
    instr_done_o    = 1'b0;
    mem_err_o       = 1'b0;
    if (!rst_i) begin
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          alu_op_o    = 2'b10;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_b_o = 2'b11;
          alu_op_o    = 2'b10;
        end
        S_MEMADR, S_ADDIEX: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = 2'b10;
        end
        S_MEMRD: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEMWB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEMWR: begin
          mem_write_o  = 1'b1;
          iord_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_EXEC:  alu_src_a_o = 1'b1;
        S_ALUWB: begin
          reg_dst_o    = 1'b1;
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          alu_op_o        = 2'b01;
          pc_write_cond_o = 1'b1;
          pc_source_o     = 2'b01;
          instr_done_o    = 1'b1;
        end
        S_ADDIWB: begin
          reg_write_o  = 1'b1;
          instr_done_o = 1'b1;
        end
        S_JUMP: begin
          pc_write_o   = 1'b1;
          pc_source_o  = 2'b10;
          instr_done_o = 1'b1;
        end
        default: ;
      endcase
      if (timeout) begin
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_err_o   = 1'b1;
      end
    end
  end

  assign state_o = rst_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench for mips_multicycle_ctrl: per-cycle expected output words are
// queued by the stimulus and checked by an independent negedge monitor.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, instr_done, mem_err;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;

  int n_checks = 0;
  int n_fails  = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond), .pc_source_o(pc_source),
    .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
    .instr_done_o(instr_done), .mem_err_o(mem_err), .state_o(state)
  );

  // Output word layout: pcw pcwc pcsrc[2] iord mrd mwr irw rdst m2r rw srca srcb[2] op[2] done err st[4]
  function automatic logic [21:0] ev(input int st, input bit rdy, input bit to);
    logic pcw, pcwc, io, mrd, mwr, irw, rd, m2r, rw, sa, dn, er;
    logic [1:0] ps, sb, op;
    {pcw, pcwc, io, mrd, mwr, irw, rd, m2r, rw, sa, dn, er} = '0;
    {ps, sb, op} = '0;
    case (st)
      0:  begin mrd = !to; sb = 2'b01; op = 2'b10; irw = rdy; pcw = rdy; end
      1:  begin sb = 2'b11; op = 2'b10; end
      2:  begin sa = 1'b1; sb = 2'b10; op = 2'b10; end
      3:  begin mrd = !to; io = 1'b1; end
      4:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
      5:  begin mwr = !to; io = 1'b1; dn = rdy; end
      6:  begin sa = 1'b1; end
      7:  begin rd = 1'b1; rw = 1'b1; dn = 1'b1; end
      8:  begin sa = 1'b1; op = 2'b01; pcwc = 1'b1; ps = 2'b01; dn = 1'b1; end
      9:  begin sa = 1'b1; sb = 2'b10; op = 2'b10; end
      10: begin rw = 1'b1; dn = 1'b1; end
      11: begin pcw = 1'b1; ps = 2'b10; dn = 1'b1; end
      default: ;
    endcase
    er = to;
    return {pcw, pcwc, ps, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, op, dn, er, 4'(st)};
  endfunction

  task automatic step(input bit r, input bit rdy, input logic [5:0] opc, input int st,
                      input bit to, input string nm);
    rst       = r;
    mem_ready = rdy;
    opcode    = opc;
    exp_q.push_back(r ? 22'd0 : ev(st, rdy, to));
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [21:0] act, exp_v;
    string       nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             instr_done, mem_err, state};
      n_checks++;
      if (act !== exp_v) begin
        n_fails++;
        $display("FAIL %s: outputs got %b expected %b", nm, act, exp_v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
    @(posedge clk); #1;
    // Reset held, then lw with memory always ready
    for (int i = 0; i < 3; i++) step(1, 1, 6'h23, 0, 0, "reset");
    step(0, 1, 6'h23, 0, 0, "lw fetch");
    step(0, 1, 6'h23, 1, 0, "lw decode");
    step(0, 1, 6'h23, 2, 0, "lw memadr");
    step(0, 1, 6'h23, 3, 0, "lw memrd");
    step(0, 1, 6'h23, 4, 0, "lw memwb");
    // R-type
    step(0, 1, 6'h00, 0, 0, "r fetch");
    step(0, 1, 6'h00, 1, 0, "r decode");
    step(0, 1, 6'h00, 6, 0, "r exec");
    step(0, 1, 6'h00, 7, 0, "r aluwb");
    // beq and j
    step(0, 1, 6'h04, 0, 0, "beq fetch");
    step(0, 1, 6'h04, 1, 0, "beq decode");
    step(0, 1, 6'h04, 8, 0, "beq branch");
    step(0, 1, 6'h02, 0, 0, "j fetch");
    step(0, 1, 6'h02, 1, 0, "j decode");
    step(0, 1, 6'h02, 11, 0, "j jump");
    // addi
    step(0, 1, 6'h08, 0, 0, "addi fetch");
    step(0, 1, 6'h08, 1, 0, "addi decode");
    step(0, 1, 6'h08, 9, 0, "addi exec");
    step(0, 1, 6'h08, 10, 0, "addi wb");
    // sw with a three-cycle memory stall
    step(0, 1, 6'h2B, 0, 0, "sw fetch");
    step(0, 1, 6'h2B, 1, 0, "sw decode");
    step(0, 1, 6'h2B, 2, 0, "sw memadr");
    for (int i = 0; i < 3; i++) step(0, 0, 6'h2B, 5, 0, "sw memwr stall");
    step(0, 1, 6'h2B, 5, 0, "sw memwr ready");
    // FETCH timeout: 15 stalled cycles, abort on the 16th
    for (int i = 0; i < 15; i++) step(0, 0, 6'h3F, 0, 0, "fetch stall");
    step(0, 0, 6'h3F, 0, 1, "fetch timeout");
    // Undefined opcode returns to FETCH with nothing retired
    step(0, 1, 6'h3F, 0, 0, "bad fetch");
    step(0, 1, 6'h3F, 1, 0, "bad decode");
    // lw whose memory answers exactly at the timeout boundary
    step(0, 1, 6'h23, 0, 0, "lw2 fetch");
    step(0, 1, 6'h23, 1, 0, "lw2 decode");
    step(0, 1, 6'h23, 2, 0, "lw2 memadr");
    for (int i = 0; i < 15; i++) step(0, 0, 6'h23, 3, 0, "lw2 memrd stall");
    step(0, 1, 6'h23, 3, 0, "lw2 memrd ready at limit");
    step(0, 1, 6'h23, 4, 0, "lw2 memwb");
    // Reset asserted mid-instruction in MEMRD
    step(0, 1, 6'h23, 0, 0, "lw3 fetch");
    step(0, 1, 6'h23, 1, 0, "lw3 decode");
    step(0, 1, 6'h23, 2, 0, "lw3 memadr");
    step(1, 1, 6'h23, 3, 0, "rst in memrd");
    step(0, 0, 6'h23, 0, 0, "post-rst fetch");
    step(0, 1, 6'h23, 0, 0, "post-rst fetch ready");
    step(0, 1, 6'h23, 1, 0, "post-rst decode");
    @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: queue size got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
